// File: rtl/instr_sequencer.sv
// Purpose : steps a 16x9 program memory out to a processor as Run/DIN instruction
//           issues, waits for Done after each, handles move-immediate pairs and timeouts.
// Ports   : Clock/Resetn; prog_we/prog_addr/prog_data load memory while idle;
//           Start/Len launch a run; Done/Bus come back from the processor;
//           DIN/Run feed the processor; Busy/Finish/Err/Result report status.
module instr_sequencer #(
   parameter logic [2:0] MVI_OP  = 3'b011,
   parameter int         TIMEOUT = 8
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [8:0] prog_data,
   input  logic       Start,
   input  logic [4:0] Len,
   input  logic       Done,
   input  logic [8:0] Bus,
   output logic [8:0] DIN,
   output logic       Run,
   output logic       Busy,
   output logic       Finish,
   output logic       Err,
   output logic [8:0] Result
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, IMM, WAIT, DONE_ST} state_t;

   state_t        state;
   logic [8:0]    mem [16];
   logic [4:0]    pc;
   logic [4:0]    len_q;
   logic [CW-1:0] wait_cnt;

   logic [4:0]    pc_adv;     // PC after the current IMM/WAIT completes
   logic [3:0]    imm_idx;    // address of the immediate operand
   logic [8:0]    word_pc;
   logic [2:0]    adv_op;
   logic          len_ok;
   logic          first_bad;  // first word is MVI but the program has no room for its operand
   logic          adv_bad;    // the word about to be fetched is MVI with no operand left

   always_comb begin
      pc_adv    = (state == IMM) ? pc + 5'd2 : pc + 5'd1;
      imm_idx   = pc[3:0] + 4'd1;
      word_pc   = mem[pc[3:0]];
      adv_op    = mem[pc_adv[3:0]][8:6];
      len_ok    = (Len != 5'd0) && (Len <= 5'd16);
      first_bad = (mem[0][8:6] == MVI_OP) && (Len == 5'd1);
      adv_bad   = (adv_op == MVI_OP) && (pc_adv == len_q - 5'd1);
   end

   // Combinational read from registered state/PC; zero whenever nothing is being issued.
   always_comb begin
      DIN = 9'h000;
      case (state)
         FETCH:   DIN = word_pc;
         IMM:     DIN = mem[imm_idx];
         WAIT:    DIN = word_pc;
         default: DIN = 9'h000;
      endcase
   end

   // Program store survives reset; locked while a program is running.
   always_ff @(posedge Clock) begin
      if (prog_we && !Busy) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // Run is registered, so the "no Run on a dangling MVI" decision is taken
   // on the edge that enters FETCH, using the word that FETCH will present.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state    <= IDLE;
         pc       <= 5'd0;
         len_q    <= 5'd0;
         wait_cnt <= '0;
         Run      <= 1'b0;
         Busy     <= 1'b0;
         Finish   <= 1'b0;
         Err      <= 1'b0;
         Result   <= 9'h000;
      end else begin
         Run    <= 1'b0;
         Finish <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  if (len_ok) begin
                     Err      <= 1'b0;
                     pc       <= 5'd0;
                     len_q    <= Len;
                     wait_cnt <= '0;
                     Busy     <= 1'b1;
                     Run      <= !first_bad;
                     state    <= FETCH;
                  end else begin
                     Err <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (word_pc[8:6] == MVI_OP) begin
                  if (pc == len_q - 5'd1) begin
                     Err   <= 1'b1;
                     Busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= IMM;
                  end
               end else begin
                  state <= WAIT;
               end
            end
            IMM, WAIT: begin
               if (Done) begin
                  Result   <= Bus;
                  pc       <= pc_adv;
                  wait_cnt <= '0;
                  // Completion is tested on the new PC before memory is read again.
                  if (pc_adv >= len_q) begin
                     Finish <= 1'b1;
                     state  <= DONE_ST;
                  end else begin
                     Run   <= !adv_bad;
                     state <= FETCH;
                  end
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  // This cycle brings the count to TIMEOUT: abandon without Finish.
                  Err      <= 1'b1;
                  Busy     <= 1'b0;
                  wait_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            DONE_ST: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose : self-checking bench for instr_sequencer: directed table, reset and
//           lockout sequences, then randomized programs against a program-level model.
// Ports   : none; drives every DUT port and plays the processor (Done/Bus responder).
module tb_instr_sequencer;

   localparam logic [2:0] MVI     = 3'b011;
   localparam int         TIMEOUT = 8;

   logic       Clock;
   logic       Resetn;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [8:0] prog_data;
   logic       Start;
   logic [4:0] Len;
   logic       Done;
   logic [8:0] Bus;
   logic [8:0] DIN;
   logic       Run;
   logic       Busy;
   logic       Finish;
   logic       Err;
   logic [8:0] Result;

   instr_sequencer #(.MVI_OP(MVI), .TIMEOUT(TIMEOUT)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .prog_we  (prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .Start    (Start),
      .Len      (Len),
      .Done     (Done),
      .Bus      (Bus),
      .DIN      (DIN),
      .Run      (Run),
      .Busy     (Busy),
      .Finish   (Finish),
      .Err      (Err),
      .Result   (Result)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (program level) ----------------
   logic [8:0] tmem [16];       // what the bench has written into program memory
   int         dly  [16];       // Done=0 cycles the processor takes for instruction k
   logic [8:0] busv [16];       // Bus value returned for instruction k
   logic [8:0] e_fetch [$];     // DIN expected with each Run
   logic [8:0] e_hold  [$];     // DIN expected while waiting for Done
   int         e_fin;
   logic       e_err;
   logic [8:0] exp_result;

   function automatic void predict(input int len);
      int pc;
      int k;
      logic mvi;
      e_fetch.delete();
      e_hold.delete();
      e_fin = 0;
      if (len < 1 || len > 16) begin
         e_err = 1'b1;
         return;
      end
      e_err = 1'b0;
      pc = 0;
      for (int it = 0; it < 17; it++) begin
         if (pc >= len) begin
            e_fin = 1;
            return;
         end
         mvi = (tmem[pc][8:6] == MVI);
         if (mvi && pc == len - 1) begin
            e_err = 1'b1;
            return;
         end
         e_fetch.push_back(tmem[pc]);
         e_hold.push_back(mvi ? tmem[pc + 1] : tmem[pc]);
         k = e_fetch.size() - 1;
         if (dly[k] >= TIMEOUT) begin
            e_err = 1'b1;
            return;
         end
         exp_result = busv[k];
         pc += mvi ? 2 : 1;
      end
   endfunction

   // ---------------- drivers ----------------
   // All tasks start and end at a sample point (#1 after a rising edge).
   task automatic load_word(input int a, input logic [8:0] d);
      prog_we   = 1'b1;
      prog_addr = 4'(a);
      prog_data = d;
      @(posedge Clock); #1;
      prog_we   = 1'b0;
      tmem[a]   = d;
   endtask

   // Launch a run and act as the processor until the sequencer goes idle.
   // With lock set, Start and prog_we are hammered for every busy cycle.
   task automatic run_program(input int len, input bit lock, output int n_run, output int n_fin);
      bit pending, busy_seen, ended;
      int widx, k;
      n_run = 0; n_fin = 0; pending = 0; busy_seen = 0; ended = 0; widx = 0;
      Len   = 5'(len);
      Start = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge Clock); #1;
         Start   = 1'b0;
         prog_we = 1'b0;
         Done    = 1'b0;
         Bus     = 9'($urandom);
         if (Busy) busy_seen = 1;
         if (Finish) n_fin++;
         if (Run) begin
            if (n_run < e_fetch.size())
               chk($sformatf("run%0d DIN", n_run), DIN, e_fetch[n_run]);
            n_run++;
            pending = 1;
            widx    = 0;
            Done    = 1'($urandom);   // Done during FETCH must be ignored
         end else if (pending) begin
            k = n_run - 1;
            if (k < e_hold.size()) begin
               chk($sformatf("hold%0d DIN", k), DIN, e_hold[k]);
               if (widx == dly[k]) begin
                  Done    = 1'b1;
                  Bus     = busv[k];
                  pending = 0;
               end else begin
                  widx++;
                  if (widx >= TIMEOUT) pending = 0;
               end
            end else begin
               pending = 0;
            end
         end else begin
            Done = 1'($urandom);       // Done outside IMM/WAIT must be ignored
         end
         if (Busy) Len = 5'($urandom); // length must have been latched at Start
         if (lock && Busy) begin
            Start     = 1'b1;
            prog_we   = 1'b1;
            prog_addr = 4'($urandom_range(0, 1));
            prog_data = 9'($urandom);
         end
         if ((busy_seen && !Busy) || (!busy_seen && cyc >= 3)) begin
            ended = 1;
            break;
         end
      end
      Done    = 1'b0;
      Start   = 1'b0;
      prog_we = 1'b0;
      chk("run ended in budget", 32'(ended), 32'd1);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [8:0] w0, w1, w2, w3;
      int         len;
      int         dly;
      logic [8:0] bus0;
      int         e_runs;
      int         e_fin;
      logic       e_err;
      logic [8:0] e_res;
   } vec_t;

   function automatic vec_t mk(input logic [8:0] w0, w1, w2, w3, input int len, dl,
                               input logic [8:0] bus0, input int er, ef,
                               input logic ee, input logic [8:0] eres);
      vec_t v;
      v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
      v.len = len; v.dly = dl; v.bus0 = bus0;
      v.e_runs = er; v.e_fin = ef; v.e_err = ee; v.e_res = eres;
      return v;
   endfunction

   vec_t tbl [11];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int nr, nf, len;
      // w0..w3, len, dly, bus0 | runs, finish, err, result
      tbl[0]  = mk(9'h0C1, 9'h1CF, 9'h000, 9'h000,  2, 1, 9'h1CF, 1, 1, 1'b0, 9'h1CF); // mvi
      tbl[1]  = mk(9'h0D1, 9'h1FF, 9'h02A, 9'h000,  3, 0, 9'h055, 2, 1, 1'b0, 9'h056); // mixed
      tbl[2]  = mk(9'h02A, 9'h000, 9'h000, 9'h000,  1, 8, 9'h111, 1, 0, 1'b1, 9'h056); // timeout
      tbl[3]  = mk(9'h0C1, 9'h000, 9'h000, 9'h000,  0, 0, 9'h000, 0, 0, 1'b1, 9'h056); // Len=0
      tbl[4]  = mk(9'h0C1, 9'h1CF, 9'h000, 9'h000,  1, 0, 9'h000, 0, 0, 1'b1, 9'h056); // lone MVI
      tbl[5]  = mk(9'h02A, 9'h000, 9'h000, 9'h000, 17, 0, 9'h000, 0, 0, 1'b1, 9'h056); // Len>16
      tbl[6]  = mk(9'h02A, 9'h1FF, 9'h0C1, 9'h1CF,  4, 2, 9'h0A0, 3, 1, 1'b0, 9'h0A2);
      tbl[7]  = mk(9'h02A, 9'h1FF, 9'h0C1, 9'h000,  3, 0, 9'h011, 2, 0, 1'b1, 9'h012); // MVI last
      tbl[8]  = mk(9'h0C1, 9'h1CF, 9'h0D1, 9'h1FF,  4, 7, 9'h100, 2, 1, 1'b0, 9'h101); // max wait
      tbl[9]  = mk(9'h1FF, 9'h000, 9'h000, 9'h000,  1, 9, 9'h077, 1, 0, 1'b1, 9'h101); // timeout
      tbl[10] = mk(9'h000, 9'h001, 9'h002, 9'h003,  4, 0, 9'h1F0, 4, 1, 1'b0, 9'h1F3);

      Resetn = 1'b0; Start = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 9'h000;
      Len = 5'd0; Done = 1'b0; Bus = 9'h000;
      exp_result = 9'h000;
      for (int k = 0; k < 16; k++) begin
         tmem[k] = 9'h000; dly[k] = 0; busv[k] = 9'h000;
      end

      // Reset state, before any clock edge.
      #3;
      chk("reset DIN", DIN, 0);
      chk("reset Run", Run, 0);
      chk("reset Busy", Busy, 0);
      chk("reset Finish", Finish, 0);
      chk("reset Err", Err, 0);
      chk("reset Result", Result, 0);
      @(posedge Clock); #1;
      Resetn = 1'b1;

      // Directed table.
      for (int i = 0; i < 11; i++) begin
         load_word(0, tbl[i].w0);
         load_word(1, tbl[i].w1);
         load_word(2, tbl[i].w2);
         load_word(3, tbl[i].w3);
         for (int k = 0; k < 16; k++) begin
            dly[k]  = tbl[i].dly;
            busv[k] = tbl[i].bus0 + 9'(k);
         end
         predict(tbl[i].len);
         run_program(tbl[i].len, 1'b0, nr, nf);
         chk($sformatf("t%0d runs", i), nr, tbl[i].e_runs);
         chk($sformatf("t%0d finish", i), nf, tbl[i].e_fin);
         chk($sformatf("t%0d Err", i), Err, tbl[i].e_err);
         chk($sformatf("t%0d Result", i), Result, tbl[i].e_res);
         chk($sformatf("t%0d Busy", i), Busy, 0);
         chk($sformatf("t%0d idle DIN", i), DIN, 0);
      end

      // Reset in the middle of an MVI (IMM state).
      load_word(0, 9'h0C1);
      load_word(1, 9'h1CF);
      Len = 5'd2; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      chk("mid fetch Run", Run, 1);
      chk("mid fetch DIN", DIN, 9'h0C1);
      @(posedge Clock); #1;
      chk("mid imm DIN", DIN, 9'h1CF);
      chk("mid imm Busy", Busy, 1);
      #2 Resetn = 1'b0;
      #1;
      chk("mid rst DIN", DIN, 0);
      chk("mid rst Run", Run, 0);
      chk("mid rst Busy", Busy, 0);
      chk("mid rst Finish", Finish, 0);
      chk("mid rst Err", Err, 0);
      chk("mid rst Result", Result, 0);
      @(posedge Clock); #1;
      Resetn = 1'b1;
      exp_result = 9'h000;
      for (int k = 0; k < 16; k++) begin dly[k] = 1; busv[k] = 9'h0AA + 9'(k); end
      predict(2);
      run_program(2, 1'b0, nr, nf);
      chk("rerun runs", nr, 1);
      chk("rerun finish", nf, 1);
      chk("rerun Err", Err, 0);
      chk("rerun Result", Result, 9'h0AA);

      // Busy lockout: Start/prog_we during the run are ignored; memory intact after.
      for (int k = 0; k < 16; k++) begin dly[k] = 2; busv[k] = 9'h033; end
      predict(2);
      run_program(2, 1'b1, nr, nf);
      chk("lock runs", nr, 1);
      chk("lock finish", nf, 1);
      chk("lock Result", Result, 9'h033);
      chk("lock Busy", Busy, 0);
      for (int k = 0; k < 16; k++) begin dly[k] = 0; busv[k] = 9'h044; end
      predict(2);
      run_program(2, 1'b0, nr, nf);
      chk("after lock runs", nr, 1);
      chk("after lock Result", Result, 9'h044);

      // Randomized programs against the model.
      for (int i = 0; i < 40; i++) begin
         for (int a = 0; a < 16; a++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 2) == 0) ? MVI : 3'($urandom);
            load_word(a, {op, 6'($urandom)});
         end
         for (int k = 0; k < 16; k++) begin
            dly[k]  = ($urandom_range(0, 11) == 0) ? $urandom_range(8, 10) : $urandom_range(0, 4);
            busv[k] = 9'($urandom);
         end
         if ($urandom_range(0, 9) == 0)
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
         else
            len = $urandom_range(1, 16);
         predict(len);
         run_program(len, (i % 5 == 2), nr, nf);
         chk($sformatf("r%0d runs", i), nr, e_fetch.size());
         chk($sformatf("r%0d finish", i), nf, e_fin);
         chk($sformatf("r%0d Err", i), Err, e_err);
         chk($sformatf("r%0d Result", i), Result, exp_result);
         chk($sformatf("r%0d Busy", i), Busy, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
